// File: rtl/rssb_loader.sv
// ============================================================================
//  Module      : rssb_loader
//  Description : Streams a program into the RSSB data memory over valid/ready,
//                holding the core in reset until the last byte is committed.
//                Optional trailing checksum byte: define RSSB_LOADER_CSUM_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rssb_loader #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] last_addr,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   output logic             core_rst,
   output logic             done,
   output logic             error,
   output logic [WIDTH:0]   count
);

`ifdef RSSB_LOADER_CSUM_EN
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_RUN   = 2'd2,
      S_ERROR = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_RUN   = 2'd2
   } state_t;
`endif

   localparam logic [WIDTH-1:0] c_PTR_ONE = 1;
   localparam logic [WIDTH:0]   c_CNT_ONE = 1;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] last_q, last_d;
   logic [WIDTH-1:0] ptr_q, ptr_d;
   logic [WIDTH:0]   count_q, count_d;
   logic             we_q, we_d;
   logic [WIDTH-1:0] addr_q, addr_d;
   logic [WIDTH-1:0] wdata_q, wdata_d;
   logic             run_q, run_d;
`ifdef RSSB_LOADER_CSUM_EN
   logic             csum_ph_q, csum_ph_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [WIDTH-1:0] w_sum_total;
`endif

   logic w_xfer;
   logic w_last;
   logic w_restart;

   assign w_xfer = in_valid && (state_q == S_LOAD);
   assign w_last = (ptr_q == last_q);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         last_q    <= '0;
         ptr_q     <= '0;
         count_q   <= '0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         run_q     <= 1'b0;
`ifdef RSSB_LOADER_CSUM_EN
         csum_ph_q <= 1'b0;
         sum_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         ptr_q     <= ptr_d;
         count_q   <= count_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         run_q     <= run_d;
`ifdef RSSB_LOADER_CSUM_EN
         csum_ph_q <= csum_ph_d;
         sum_q     <= sum_d;
`endif
      end
   end

   // start is honoured everywhere except mid-load
   assign w_restart = start && (state_q != S_LOAD);

`ifdef RSSB_LOADER_CSUM_EN
   assign w_sum_total = sum_q + in_data;
`endif

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      ptr_d     = ptr_q;
      count_d   = count_q;
      we_d      = 1'b0;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      run_d     = 1'b0;
`ifdef RSSB_LOADER_CSUM_EN
      csum_ph_d = csum_ph_q;
      sum_d     = sum_q;
`endif
      if (w_restart) begin
         state_d   = S_LOAD;
         last_d    = last_addr;
         ptr_d     = '0;
         count_d   = '0;
`ifdef RSSB_LOADER_CSUM_EN
         csum_ph_d = 1'b0;
         sum_d     = '0;
`endif
      end else if (state_q == S_RUN) begin
         // core release lags entry into RUN by one edge so the final write lands first
         run_d = 1'b1;
      end else if (w_xfer) begin
`ifdef RSSB_LOADER_CSUM_EN
         if (csum_ph_q) begin
            csum_ph_d = 1'b0;
            state_d   = (w_sum_total == '0) ? S_RUN : S_ERROR;
         end else begin
            we_d    = 1'b1;
            addr_d  = ptr_q;
            wdata_d = in_data;
            ptr_d   = ptr_q + c_PTR_ONE;
            count_d = count_q + c_CNT_ONE;
            sum_d   = w_sum_total;
            if (w_last) begin
               csum_ph_d = 1'b1;
            end
         end
`else
         we_d    = 1'b1;
         addr_d  = ptr_q;
         wdata_d = in_data;
         ptr_d   = ptr_q + c_PTR_ONE;
         count_d = count_q + c_CNT_ONE;
         if (w_last) begin
            state_d = S_RUN;
         end
`endif
      end
   end

   assign in_ready  = (state_q == S_LOAD);
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign core_rst  = run_q;
   assign done      = run_q;
   assign count     = count_q;
`ifdef RSSB_LOADER_CSUM_EN
   assign error     = (state_q == S_ERROR);
`else
   assign error     = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rssb_loader.sv
// ============================================================================
//  Module      : tb_rssb_loader
//  Description : Self-checking bench for rssb_loader; write scoreboard queue.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rssb_loader;

`ifdef RSSB_LOADER_CSUM_EN
   localparam bit c_CSUM = 1'b1;
`else
   localparam bit c_CSUM = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic [7:0] last_addr = '0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = '0;
   logic       in_ready, mem_we, core_rst, done, error;
   logic [7:0] mem_addr, mem_wdata;
   logic [8:0] count;

   int errors = 0;
   int checks = 0;
   int wr_count = 0;
   logic [15:0] exp_q[$];
   logic [7:0]  payload[$];

   always #5 clk = ~clk;

   rssb_loader #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .start(start), .last_addr(last_addr),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .core_rst(core_rst), .done(done), .error(error), .count(count)
   );

   // Scoreboard: every presented write must match the next expected one
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         logic [15:0] e;
         wr_count++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL write_unexpected: got addr=%02h data=%02h, required none", mem_addr, mem_wdata);
         end else begin
            e = exp_q.pop_front();
            if ({mem_addr, mem_wdata} !== e) begin
               errors++;
               $display("FAIL write_data: got addr=%02h data=%02h, required addr=%02h data=%02h",
                        mem_addr, mem_wdata, e[15:8], e[7:0]);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [7:0] la, input bit gapped);
      int n;
      int wr0;
      logic [7:0] s;
      n = payload.size();
      wr0 = wr_count;
      s = '0;
      start = 1'b1;
      last_addr = la;
      tick();
      start = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || core_rst !== 1'b0 || done !== 1'b0 || count !== 9'd0 || error !== 1'b0) begin
         errors++;
         $display("FAIL load_start: got rdy=%b crst=%b done=%b cnt=%0d err=%b, required 1 0 0 0 0",
                  in_ready, core_rst, done, count, error);
      end
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_data = payload[i];
         exp_q.push_back({8'(i), payload[i]});
         s = s + payload[i];
         tick();
         checks++;
         if (mem_we !== 1'b1 || mem_addr !== 8'(i)) begin
            errors++;
            $display("FAIL load_write_strobe: got we=%b addr=%02h, required we=1 addr=%02h", mem_we, mem_addr, 8'(i));
         end
         if (gapped && (c_CSUM || i != n - 1)) begin
            in_valid = 1'b0;
            tick();
            checks++;
            if (mem_we !== 1'b0) begin
               errors++;
               $display("FAIL gap_no_write: got we=%b, required 0", mem_we);
            end
         end
      end
      if (c_CSUM) begin
         in_valid = 1'b1;
         in_data = 8'd0 - s;
         tick();
      end
      in_valid = 1'b0;
      checks++;
      if (in_ready !== 1'b0 || core_rst !== 1'b0) begin
         errors++;
         $display("FAIL load_end_hold: got rdy=%b crst=%b, required 0 0", in_ready, core_rst);
      end
      tick();
      checks++;
      if (core_rst !== 1'b1 || done !== 1'b1 || count !== 9'(n) || error !== 1'b0 || mem_we !== 1'b0) begin
         errors++;
         $display("FAIL load_release: got crst=%b done=%b cnt=%0d err=%b we=%b, required 1 1 %0d 0 0",
                  core_rst, done, count, error, mem_we, n);
      end
      checks++;
      if (wr_count - wr0 != n || exp_q.size() != 0) begin
         errors++;
         $display("FAIL load_write_total: got %0d writes (%0d pending), required %0d",
                  wr_count - wr0, exp_q.size(), n);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      in_valid = 1'b1;
      in_data = 8'hA5;
      tick();
      tick();
      checks++;
      if ({in_ready, mem_we, mem_addr, mem_wdata, core_rst, done, error, count} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got rdy=%b we=%b a=%02h d=%02h crst=%b done=%b err=%b cnt=%0d, required all 0",
                  in_ready, mem_we, mem_addr, mem_wdata, core_rst, done, error, count);
      end
      in_valid = 1'b0;
      rst = 1'b1;
      tick();
      checks++;
      if (in_ready !== 1'b0 || core_rst !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset: got rdy=%b crst=%b, required 0 0", in_ready, core_rst);
      end
   endtask

   task automatic test_back_to_back();
      payload = '{8'h05, 8'h0A, 8'hFF, 8'h80};
      do_load(8'd3, 1'b0);
   endtask

   task automatic test_gapped();
      payload = '{8'h3C, 8'hC3};
      do_load(8'd1, 1'b1);
   endtask

   task automatic test_run_ignores_valid();
      int wr0;
      wr0 = wr_count;
      in_valid = 1'b1;
      in_data = 8'h77;
      tick();
      tick();
      in_valid = 1'b0;
      checks++;
      if (wr_count != wr0 || in_ready !== 1'b0 || core_rst !== 1'b1) begin
         errors++;
         $display("FAIL run_ignores_valid: got writes=%0d rdy=%b crst=%b, required 0 0 1",
                  wr_count - wr0, in_ready, core_rst);
      end
   endtask

   task automatic test_reprogram();
      payload = '{8'h42};
      do_load(8'd0, 1'b0);
   endtask

   task automatic test_reset_mid_load();
      int wr0;
      start = 1'b1;
      last_addr = 8'd3;
      tick();
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1;
         in_data = 8'h90 + 8'(i);
         exp_q.push_back({8'(i), 8'h90 + 8'(i)});
         tick();
      end
      rst = 1'b0;
      in_data = 8'h99;
      tick();
      wr0 = wr_count;
      checks++;
      if (in_ready !== 1'b0 || core_rst !== 1'b0 || mem_we !== 1'b0 || count !== 9'd0) begin
         errors++;
         $display("FAIL midload_reset: got rdy=%b crst=%b we=%b cnt=%0d, required 0 0 0 0",
                  in_ready, core_rst, mem_we, count);
      end
      rst = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      in_valid = 1'b0;
      checks++;
      if (wr_count != wr0 || in_ready !== 1'b0 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL midload_no_more_writes: got writes=%0d rdy=%b pending=%0d, required 0 0 0",
                  wr_count - wr0, in_ready, exp_q.size());
      end
      payload = '{8'h11, 8'h22};
      do_load(8'd1, 1'b0);
   endtask

   task automatic test_full_range();
      payload.delete();
      for (int i = 0; i < 256; i++) payload.push_back(8'(i * 7 + 3));
      do_load(8'hFF, 1'b0);
   endtask

   task automatic test_error_flag();
      checks++;
      if (error !== 1'b0) begin
         errors++;
         $display("FAIL error_idle: got %b, required 0", error);
      end
`ifdef RSSB_LOADER_CSUM_EN
      begin
         int wr0;
         wr0 = wr_count;
         start = 1'b1;
         last_addr = 8'd2;
         tick();
         start = 1'b0;
         for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data = 8'(i + 1);
            exp_q.push_back({8'(i), 8'(i + 1)});
            tick();
         end
         in_data = 8'hFB;
         tick();
         in_valid = 1'b0;
         checks++;
         if (error !== 1'b1 || in_ready !== 1'b0 || core_rst !== 1'b0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL csum_bad: got err=%b rdy=%b crst=%b we=%b, required 1 0 0 0",
                     error, in_ready, core_rst, mem_we);
         end
         tick();
         checks++;
         if (error !== 1'b1 || core_rst !== 1'b0 || wr_count - wr0 != 3) begin
            errors++;
            $display("FAIL csum_bad_hold: got err=%b crst=%b writes=%0d, required 1 0 3",
                     error, core_rst, wr_count - wr0);
         end
         payload = '{8'h01, 8'h02, 8'h03};
         do_load(8'd2, 1'b0);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_run_ignores_valid();
      test_gapped();
      test_reprogram();
      test_reset_mid_load();
      test_full_range();
      test_error_flag();
      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/rssb_loader.md
Name: rssb_loader

Overview:
- Program loader that sits directly upstream of the RSSB core and its data memory.
- Accepts a byte stream over a valid/ready handshake and writes the bytes to consecutive memory addresses starting at 0.
- Holds the core in reset while loading, then releases it once the last byte has been committed.
- Its write outputs drive the memory's write port; the core's memory mux defers to it while the core is held in reset.

Parameters:
WIDTH, 8, data and address width; matches the core's WIDTH.

Ports:
clk        input   1        clock; all state updates on the rising edge
rst        input   1        synchronous, active-low reset (0 at a rising edge resets the block)
start      input   1        begin a load; sampled in IDLE, RUN and ERROR only
last_addr  input   WIDTH    final address to write; captured when start is accepted
in_valid   input   1        source has a byte on in_data
in_data    input   WIDTH    program/data byte
in_ready   output  1        loader accepts a byte this cycle
mem_we     output  1        memory write strobe, one-cycle pulse per byte
mem_addr   output  WIDTH    memory write address
mem_wdata  output  WIDTH    memory write data
core_rst   output  1        active-low reset to the core; 0 holds the core in reset
done       output  1        load completed; core running
error      output  1        checksum failure (optional feature only)
count      output  WIDTH+1  bytes accepted in the current load

Behaviour:
- Reset (rst=0 at an edge):
  - state=IDLE.
  - in_ready, mem_we, mem_addr, mem_wdata, core_rst, done, error and count all reset to 0.
  - Reset mid-load aborts the load; memory already written is not cleared.
- States: IDLE, LOAD, RUN, ERROR (ERROR only with the optional feature).
- in_ready = (state==LOAD). It is a registered state decode, not dependent on in_valid.
- Transfer: in_valid && in_ready at a rising edge.
- IDLE:
  - start=1 -> LOAD.
  - Capture last_addr, clear the write pointer to 0, clear count.
- LOAD, on each transfer:
  - At the same edge: register mem_we=1, mem_addr=ptr, mem_wdata=in_data; ptr++; count++.
  - The write is therefore presented during the cycle after the handshake and commits at the next edge.
  - Back-to-back transfers every cycle are supported (full throughput).
  - in_valid=0 produces no write; mem_we returns to 0 the cycle after the last transfer.
- Last byte (transfer with ptr==captured last_addr):
  - LOAD -> RUN at the same edge; in_ready drops.
  - core_rst and done are set one edge later, i.e. the same edge that commits the final write. The core therefore never sees a partially written program.
- Boundaries:
  - last_addr=0 loads one byte.
  - last_addr=2^WIDTH-1 loads 2^WIDTH bytes; ptr never wraps because the load stops at last_addr.
- start in LOAD is ignored.
- RUN:
  - core_rst=1, done=1, in_ready=0; in_valid is ignored.
  - start=1 -> LOAD. core_rst and done clear at that same edge and the pointer restarts at 0 (re-program).
- mem_addr and mem_wdata hold their last values when mem_we=0.

Optional Feature:
- Macro: RSSB_LOADER_CSUM_EN.
- Defined:
  - After the last data byte the loader stays in LOAD (checksum phase) and accepts exactly one more byte.
  - That byte is not written to memory and not counted.
  - Check: sum of all data bytes plus the checksum byte, mod 2^WIDTH, must equal 0.
  - Pass -> RUN, with core_rst and done rising one edge after the checksum handshake.
  - Fail -> ERROR: error=1, core_rst=0, in_ready=0.
  - ERROR is left only by start (-> LOAD, error cleared) or by rst.
- Undefined: no checksum phase, error tied to 0, no ERROR state.

Test Plan:
- Reset: hold rst=0 for 2 cycles -> every output is 0 and in_ready=0, including while in_valid=1.
- Back-to-back load: start with last_addr=3, then stream 05,0A,FF,80 on consecutive cycles.
  - Four mem_we pulses on consecutive cycles: addr 0..3 with data 05,0A,FF,80.
  - core_rst=1 and done=1 on the edge committing addr 3; count=4.
- Gapped source: last_addr=1 with in_valid alternating 1,0 -> exactly 2 writes (addr 0 and 1), no mem_we on the gap cycles.
- Re-program: start while in RUN -> core_rst=0 at the same edge. Then last_addr=0 with byte 42 -> single write addr0=42, then RUN.
- Reset mid-load: rst=0 after 2 of 4 bytes -> IDLE, core_rst=0, no further writes. The next start writes from addr 0.
- With RSSB_LOADER_CSUM_EN, bytes 01,02,03 and last_addr=2:
  - Checksum FA -> RUN, core_rst=1.
  - Checksum FB -> error=1, core_rst=0, exactly 3 writes.
  - A following start clears error.
